// File: rtl/ap_perf_pkg.sv
// ap_perf_pkg
//   Shared definitions for the ap_ctrl_chain performance monitor:
//   - rd_sel encoding of the statistic read port
//   - ts_t: timestamp type for the default timestamp width
//   - chan_stats_t: per-channel sticky status flags
package ap_perf_pkg;

  localparam logic [2:0] SEL_TXN         = 3'd0;
  localparam logic [2:0] SEL_LAST_LAT    = 3'd1;
  localparam logic [2:0] SEL_MIN_LAT     = 3'd2;
  localparam logic [2:0] SEL_MAX_LAT     = 3'd3;
  localparam logic [2:0] SEL_LAST_II     = 3'd4;
  localparam logic [2:0] SEL_DONE_STALL  = 3'd5;
  localparam logic [2:0] SEL_START_STALL = 3'd6;
  localparam logic [2:0] SEL_STATUS      = 3'd7;

  localparam int unsigned TS_W_DEFAULT = 24;
  typedef logic [TS_W_DEFAULT-1:0] ts_t;

  // Sticky per-channel flags; packed order matches the status word.
  typedef struct packed {
    logic underflow;
    logic overflow;
  } chan_stats_t;

endpackage

// File: rtl/ap_ctrl_perf_monitor_if.sv
// ap_ctrl_perf_monitor_if
//   Bundle of NUM_CH ap_ctrl_chain block-level handshakes.
//   master: the side driving the handshake (HLS top / testbench)
//   slave : the passive observer (performance monitor), all inputs
interface ap_ctrl_perf_monitor_if #(
  parameter int unsigned NUM_CH = 8
);
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;

  modport master (output ap_start, ap_ready, ap_done, ap_continue);
  modport slave  (input  ap_start, ap_ready, ap_done, ap_continue);
endinterface

// File: rtl/ap_ctrl_chan_monitor.sv
// ap_ctrl_chan_monitor
//   Statistics for one ap_ctrl_chain channel: timestamp FIFO (MAX_OUT deep)
//   for overlapped transactions, latency last/min/max, initiation interval,
//   transaction count and sticky overflow/underflow flags.
//   Stall counters exist only when PERF_MON_STALL_EN is defined; otherwise
//   done_stall/start_stall are tied to zero.
//   Ports: clock, reset_n (async, active-low), enable, clear (sync),
//          ts (global timestamp), one-bit handshake inputs, statistic outputs.
module ap_ctrl_chan_monitor
  import ap_perf_pkg::*;
#(
  parameter  int unsigned MAX_OUT = 4,
  parameter  int unsigned TS_W    = 24,
  parameter  int unsigned CNT_W   = 32,
  localparam int unsigned AW      = $clog2(MAX_OUT),
  localparam int unsigned OCC_W   = AW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [TS_W-1:0]  ts,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  output logic [CNT_W-1:0] txn_count,
  output logic [TS_W-1:0]  last_lat,
  output logic [TS_W-1:0]  min_lat,
  output logic [TS_W-1:0]  max_lat,
  output logic [TS_W-1:0]  last_ii,
  output logic [CNT_W-1:0] done_stall,
  output logic [CNT_W-1:0] start_stall,
  output chan_stats_t      flags,
  output logic [OCC_W-1:0] occupancy
);

  logic [TS_W-1:0]  mem_q [MAX_OUT];
  logic [TS_W-1:0]  mem_d [MAX_OUT];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] txn_q, txn_d;
  logic [TS_W-1:0]  last_lat_q, last_lat_d, min_lat_q, min_lat_d;
  logic [TS_W-1:0]  max_lat_q, max_lat_d, last_ii_q, last_ii_d;
  logic [TS_W-1:0]  start_ts_q, start_ts_d;
  logic             start_vld_q, start_vld_d;
  chan_stats_t      flags_q, flags_d;

  logic             start_ev_s, done_ev_s, push_s, pop_s, full_s, empty_s;
  logic [TS_W-1:0]  lat_s;

  // Event decode, FIFO control and next-state statistics.
  always_comb begin
    start_ev_s  = enable & ap_start & ap_ready;
    done_ev_s   = enable & ap_done & ap_continue;
    empty_s     = (occ_q == '0);
    full_s      = (occ_q == OCC_W'(MAX_OUT));
    // A done frees a slot first, so a start is accepted even when full.
    pop_s       = done_ev_s & ~empty_s;
    push_s      = start_ev_s & (~full_s | pop_s);
    lat_s       = ts - mem_q[rd_ptr_q];

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    txn_d       = txn_q;
    last_lat_d  = last_lat_q;
    min_lat_d   = min_lat_q;
    max_lat_d   = max_lat_q;
    last_ii_d   = last_ii_q;
    start_ts_d  = start_ts_q;
    start_vld_d = start_vld_q;
    flags_d     = flags_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      txn_d       = '0;
      last_lat_d  = '0;
      min_lat_d   = '1;
      max_lat_d   = '0;
      last_ii_d   = '0;
      start_ts_d  = '0;
      start_vld_d = 1'b0;
      flags_d     = '0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = ts;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase

      if (start_ev_s) begin
        last_ii_d   = start_vld_q ? (ts - start_ts_q) : last_ii_q;
        start_ts_d  = ts;
        start_vld_d = 1'b1;
        flags_d.overflow = flags_q.overflow | (full_s & ~pop_s);
      end else begin
        start_vld_d = start_vld_q;
      end

      if (done_ev_s) begin
        txn_d = (txn_q == '1) ? txn_q : txn_q + CNT_W'(1);
        if (pop_s) begin
          last_lat_d = lat_s;
          min_lat_d  = (lat_s < min_lat_q) ? lat_s : min_lat_q;
          max_lat_d  = (lat_s > max_lat_q) ? lat_s : max_lat_q;
        end else begin
          flags_d.underflow = 1'b1;
        end
      end else begin
        txn_d = txn_q;
      end
    end
  end

  // Statistic and FIFO state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(MAX_OUT); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      txn_q       <= '0;
      last_lat_q  <= '0;
      min_lat_q   <= '1;
      max_lat_q   <= '0;
      last_ii_q   <= '0;
      start_ts_q  <= '0;
      start_vld_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      txn_q       <= txn_d;
      last_lat_q  <= last_lat_d;
      min_lat_q   <= min_lat_d;
      max_lat_q   <= max_lat_d;
      last_ii_q   <= last_ii_d;
      start_ts_q  <= start_ts_d;
      start_vld_q <= start_vld_d;
      flags_q     <= flags_d;
    end
  end

`ifdef PERF_MON_STALL_EN
  logic [CNT_W-1:0] dstall_q, dstall_d, sstall_q, sstall_d;

  // Saturating stall counters: done held back by continue, start held back by ready.
  always_comb begin
    dstall_d = dstall_q;
    sstall_d = sstall_q;
    if (clear) begin
      dstall_d = '0;
      sstall_d = '0;
    end else if (enable) begin
      if (ap_done & ~ap_continue & (dstall_q != '1)) dstall_d = dstall_q + CNT_W'(1);
      else dstall_d = dstall_q;
      if (ap_start & ~ap_ready & (sstall_q != '1)) sstall_d = sstall_q + CNT_W'(1);
      else sstall_d = sstall_q;
    end else begin
      dstall_d = dstall_q;
      sstall_d = sstall_q;
    end
  end

  // Stall counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dstall_q <= '0;
      sstall_q <= '0;
    end else begin
      dstall_q <= dstall_d;
      sstall_q <= sstall_d;
    end
  end

  assign done_stall  = dstall_q;
  assign start_stall = sstall_q;
`else
  assign done_stall  = '0;
  assign start_stall = '0;
`endif

  assign txn_count = txn_q;
  assign last_lat  = last_lat_q;
  assign min_lat   = min_lat_q;
  assign max_lat   = max_lat_q;
  assign last_ii   = last_ii_q;
  assign flags     = flags_q;
  assign occupancy = occ_q;

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor
//   Performance monitor for NUM_CH HLS ap_ctrl_chain interfaces. Holds the
//   free-running timestamp, one ap_ctrl_chan_monitor per channel, and a
//   registered statistic read port (1-cycle latency).
//   Optional macro: PERF_MON_STALL_EN builds the done/start stall counters.
//   Ports: clock, reset_n (async, active-low), enable, clear (sync clear of
//          statistics, timestamp keeps running), ctrl (handshake bundle,
//          slave modport), rd_en/rd_ch/rd_sel (read request),
//          rd_data/rd_valid (read response).
module ap_ctrl_perf_monitor
  import ap_perf_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 8,
  parameter  int unsigned MAX_OUT = 4,
  parameter  int unsigned TS_W    = $bits(ts_t),
  parameter  int unsigned CNT_W   = 32,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned OCC_W   = $clog2(MAX_OUT) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  ap_ctrl_perf_monitor_if.slave ctrl,
  input  logic                  rd_en,
  input  logic [CH_W-1:0]       rd_ch,
  input  logic [2:0]            rd_sel,
  output logic [CNT_W-1:0]      rd_data,
  output logic                  rd_valid
);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d, rd_mux_s;
  logic             rd_valid_q, rd_valid_d;

  logic [CNT_W-1:0] txn_s    [NUM_CH];
  logic [TS_W-1:0]  last_s   [NUM_CH];
  logic [TS_W-1:0]  min_s    [NUM_CH];
  logic [TS_W-1:0]  max_s    [NUM_CH];
  logic [TS_W-1:0]  ii_s     [NUM_CH];
  logic [CNT_W-1:0] dstall_s [NUM_CH];
  logic [CNT_W-1:0] sstall_s [NUM_CH];
  chan_stats_t      flags_s  [NUM_CH];
  logic [OCC_W-1:0] occ_s    [NUM_CH];

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    ap_ctrl_chan_monitor #(
      .MAX_OUT (MAX_OUT),
      .TS_W    (TS_W),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .clear       (clear),
      .ts          (ts_q),
      .ap_start    (ctrl.ap_start[g]),
      .ap_ready    (ctrl.ap_ready[g]),
      .ap_done     (ctrl.ap_done[g]),
      .ap_continue (ctrl.ap_continue[g]),
      .txn_count   (txn_s[g]),
      .last_lat    (last_s[g]),
      .min_lat     (min_s[g]),
      .max_lat     (max_s[g]),
      .last_ii     (ii_s[g]),
      .done_stall  (dstall_s[g]),
      .start_stall (sstall_s[g]),
      .flags       (flags_s[g]),
      .occupancy   (occ_s[g])
    );
  end

  // Statistic select; channels beyond NUM_CH read as zero.
  always_comb begin
    rd_mux_s = '0;
    if ({1'b0, rd_ch} < (CH_W + 1)'(NUM_CH)) begin
      case (rd_sel)
        SEL_TXN:         rd_mux_s = txn_s[rd_ch];
        SEL_LAST_LAT:    rd_mux_s = CNT_W'(last_s[rd_ch]);
        SEL_MIN_LAT:     rd_mux_s = CNT_W'(min_s[rd_ch]);
        SEL_MAX_LAT:     rd_mux_s = CNT_W'(max_s[rd_ch]);
        SEL_LAST_II:     rd_mux_s = CNT_W'(ii_s[rd_ch]);
        SEL_DONE_STALL:  rd_mux_s = dstall_s[rd_ch];
        SEL_START_STALL: rd_mux_s = sstall_s[rd_ch];
        SEL_STATUS:      rd_mux_s = CNT_W'({flags_s[rd_ch], occ_s[rd_ch]});
        default:         rd_mux_s = '0;
      endcase
    end else begin
      rd_mux_s = '0;
    end
  end

  // Next timestamp and read-port register values.
  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    rd_valid_d = rd_en;
    if (rd_en) begin
      rd_data_d = rd_mux_s;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Timestamp and read-port registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// tb_ap_ctrl_perf_monitor
//   Directed bench for ap_ctrl_perf_monitor with default parameters
//   (NUM_CH=8, MAX_OUT=4, TS_W=24, CNT_W=32).
module tb_ap_ctrl_perf_monitor;
  import ap_perf_pkg::*;

`ifdef PERF_MON_STALL_EN
  localparam logic [31:0] EXP_DSTALL = 32'd5;
  localparam logic [31:0] EXP_SSTALL = 32'd3;
`else
  localparam logic [31:0] EXP_DSTALL = 32'd0;
  localparam logic [31:0] EXP_SSTALL = 32'd0;
`endif
  localparam logic [31:0] MIN_RST = 32'h00FF_FFFF;

  logic        clock = 1'b0;
  logic        reset_n, enable, clear, rd_en, rd_valid;
  logic [2:0]  rd_ch, rd_sel;
  logic [31:0] rd_data;
  int          n_vec = 0;
  int          n_miss = 0;

  ap_ctrl_perf_monitor_if #(.NUM_CH(8)) ctrl_if ();

  ap_ctrl_perf_monitor dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .clear    (clear),
    .ctrl     (ctrl_if),
    .rd_en    (rd_en),
    .rd_ch    (rd_ch),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One read, then confirm rd_valid drops and rd_data holds.
  task automatic rd_stat(input logic [2:0] ch, input logic [2:0] sel,
                         input string tag, input logic [31:0] exp);
    rd_en = 1'b1; rd_ch = ch; rd_sel = sel;
    tick;
    rd_en = 1'b0;
    check_val({tag, " valid"}, {31'b0, rd_valid}, 32'd1);
    check_val(tag, rd_data, exp);
    tick;
    check_val({tag, " valid_drop"}, {31'b0, rd_valid}, 32'd0);
    check_val({tag, " hold"}, rd_data, exp);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0;
    rd_en = 1'b0; rd_ch = 3'd0; rd_sel = 3'd0;
    ctrl_if.ap_start = 8'h00; ctrl_if.ap_ready = 8'hFF;
    ctrl_if.ap_done = 8'h00; ctrl_if.ap_continue = 8'hFF;
    repeat (3) tick;
    check_val("rst rd_data", rd_data, 32'd0);
    check_val("rst rd_valid", {31'b0, rd_valid}, 32'd0);
    reset_n = 1'b1;
    tick;
    rd_stat(3'd0, SEL_TXN, "rst txn", 32'd0);
    rd_stat(3'd0, SEL_MIN_LAT, "rst min", MIN_RST);
    rd_stat(3'd0, SEL_STATUS, "rst status", 32'd0);

    // Single transaction on ch0: latency 7.
    ctrl_if.ap_start[0] = 1'b1; tick; ctrl_if.ap_start[0] = 1'b0;
    repeat (6) tick;
    ctrl_if.ap_done[0] = 1'b1; tick; ctrl_if.ap_done[0] = 1'b0;
    rd_stat(3'd0, SEL_TXN, "single txn", 32'd1);
    rd_stat(3'd0, SEL_LAST_LAT, "single last", 32'd7);
    rd_stat(3'd0, SEL_MIN_LAT, "single min", 32'd7);
    rd_stat(3'd0, SEL_MAX_LAT, "single max", 32'd7);
    rd_stat(3'd0, SEL_STATUS, "single status", 32'd0);

    // Overlap on ch2: starts at 0,3,6; dones at 20,21,22.
    for (int c = 0; c <= 22; c++) begin
      ctrl_if.ap_start[2] = (c == 0 || c == 3 || c == 6);
      ctrl_if.ap_done[2]  = (c >= 20);
      tick;
    end
    ctrl_if.ap_start[2] = 1'b0; ctrl_if.ap_done[2] = 1'b0;
    rd_stat(3'd2, SEL_TXN, "ovl txn", 32'd3);
    rd_stat(3'd2, SEL_LAST_LAT, "ovl last", 32'd16);
    rd_stat(3'd2, SEL_MIN_LAT, "ovl min", 32'd16);
    rd_stat(3'd2, SEL_MAX_LAT, "ovl max", 32'd20);
    rd_stat(3'd2, SEL_LAST_II, "ovl ii", 32'd3);

    // Overflow on ch3: 5 starts, then start+done while full at c=10.
    for (int c = 0; c <= 10; c++) begin
      ctrl_if.ap_start[3] = (c <= 4 || c == 10);
      ctrl_if.ap_done[3]  = (c == 10);
      tick;
    end
    ctrl_if.ap_start[3] = 1'b0; ctrl_if.ap_done[3] = 1'b0;
    rd_stat(3'd3, SEL_STATUS, "ovf status", 32'h0000_000C);
    rd_stat(3'd3, SEL_LAST_LAT, "ovf last", 32'd10);
    rd_stat(3'd3, SEL_TXN, "ovf txn", 32'd1);
    rd_stat(3'd3, SEL_LAST_II, "ovf ii", 32'd6);

    // Underflow on idle ch4.
    ctrl_if.ap_done[4] = 1'b1; tick; ctrl_if.ap_done[4] = 1'b0;
    rd_stat(3'd4, SEL_TXN, "udf txn", 32'd1);
    rd_stat(3'd4, SEL_STATUS, "udf status", 32'h0000_0010);
    rd_stat(3'd4, SEL_MIN_LAT, "udf min", MIN_RST);

    // Done stall on ch5: 5 cycles held by continue, then accepted.
    for (int c = 0; c <= 5; c++) begin
      ctrl_if.ap_done[5]     = 1'b1;
      ctrl_if.ap_continue[5] = (c == 5);
      tick;
    end
    ctrl_if.ap_done[5] = 1'b0; ctrl_if.ap_continue[5] = 1'b1;
    rd_stat(3'd5, SEL_DONE_STALL, "dstall", EXP_DSTALL);
    rd_stat(3'd5, SEL_TXN, "dstall txn", 32'd1);

    // Start stall on ch1: 3 cycles held by ready, then accepted.
    for (int c = 0; c <= 3; c++) begin
      ctrl_if.ap_start[1] = 1'b1;
      ctrl_if.ap_ready[1] = (c == 3);
      tick;
    end
    ctrl_if.ap_start[1] = 1'b0; ctrl_if.ap_ready[1] = 1'b1;
    rd_stat(3'd1, SEL_START_STALL, "sstall", EXP_SSTALL);
    rd_stat(3'd1, SEL_STATUS, "sstall status", 32'd1);

    // Clear together with a done event on ch6.
    ctrl_if.ap_start[6] = 1'b1; tick; ctrl_if.ap_start[6] = 1'b0;
    ctrl_if.ap_done[6] = 1'b1; clear = 1'b1; tick;
    ctrl_if.ap_done[6] = 1'b0; clear = 1'b0;
    rd_stat(3'd6, SEL_TXN, "clr txn6", 32'd0);
    rd_stat(3'd6, SEL_STATUS, "clr status6", 32'd0);
    rd_stat(3'd0, SEL_TXN, "clr txn0", 32'd0);
    rd_stat(3'd0, SEL_MIN_LAT, "clr min0", MIN_RST);
    rd_stat(3'd2, SEL_MAX_LAT, "clr max2", 32'd0);
    rd_stat(3'd3, SEL_STATUS, "clr status3", 32'd0);
    rd_stat(3'd5, SEL_DONE_STALL, "clr dstall5", 32'd0);

    // Enable low: three transactions on ch7 are ignored.
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ctrl_if.ap_start[7] = 1'b1; tick; ctrl_if.ap_start[7] = 1'b0;
      ctrl_if.ap_done[7] = 1'b1; tick; ctrl_if.ap_done[7] = 1'b0;
    end
    enable = 1'b1;
    rd_stat(3'd7, SEL_TXN, "dis txn", 32'd0);
    rd_stat(3'd7, SEL_STATUS, "dis status", 32'd0);

    // Reset while ch7 has two outstanding transactions.
    ctrl_if.ap_start[7] = 1'b1; tick; tick; ctrl_if.ap_start[7] = 1'b0;
    rd_stat(3'd7, SEL_STATUS, "busy status", 32'd2);
    reset_n = 1'b0; tick;
    check_val("midrst rd_data", rd_data, 32'd0);
    reset_n = 1'b1; tick;
    rd_stat(3'd7, SEL_STATUS, "midrst status", 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_perf_monitor.md
# ap_ctrl_perf_monitor

Synthesizable, parametrised performance monitor for HLS `ap_ctrl_chain` handshakes. It observes NUM_CH block-level control interfaces (ap_start/ap_ready/ap_done/ap_continue) and keeps per-channel transaction count, latency (last/min/max), initiation interval and stall counters. A per-channel timestamp FIFO lets it measure latency correctly when transactions overlap. It sits beside the generated top-level in on-board builds and replaces simulation-only status dumping with a register read port.

## Interface
- NUM_CH, 8: number of monitored control interfaces (1..32)
- MAX_OUT, 4: outstanding transactions tracked per channel (power of 2, ≥2)
- TS_W, 24: free-running timestamp width; latency/II are computed modulo 2^TS_W
- CNT_W, 32: width of counters and of rd_data (≥ TS_W)

- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  count events when high
- clear  in  1  synchronous clear of all statistics
- ap_start  in  NUM_CH  per-channel ap_start
- ap_ready  in  NUM_CH  per-channel ap_ready
- ap_done  in  NUM_CH  per-channel ap_done
- ap_continue  in  NUM_CH  per-channel ap_continue
- rd_en  in  1  read request
- rd_ch  in  $clog2(NUM_CH)  channel select
- rd_sel  in  3  statistic select
- rd_data  out  CNT_W  read data
- rd_valid  out  1  rd_data valid

## Operation
- Start event: ap_start & ap_ready. Done event: ap_done & ap_continue.
- Global timestamp ts increments every cycle and wraps; it runs regardless of enable.
- On start event: push ts into the channel FIFO; if last_start_valid, last_ii = ts − last_start_ts; record last_start_ts and set last_start_valid.
- On done event: pop the oldest ts; lat = ts − popped; txn_count++; last_lat = lat; min_lat = min(min_lat, lat); max_lat = max(max_lat, lat).
- Same-cycle start and done: pop, then push; allowed when the FIFO is full (occupancy unchanged).
- Start with FIFO full and no done: not pushed, sticky overflow set; II is still updated.
- Done with FIFO empty: no latency update, txn_count still increments, sticky underflow set.
- txn_count and stall counters saturate at all-ones.
- enable low: events ignored; FIFO, counters and flags hold.
- clear: equivalent to reset for all statistics, FIFOs and flags (ts is not cleared); it takes priority over same-cycle events.
- rd_sel map: 0 txn_count, 1 last_lat, 2 min_lat, 3 max_lat, 4 last_ii, 5 done_stall (ap_done & !ap_continue cycles), 6 start_stall (ap_start & !ap_ready cycles), 7 status {…, underflow, overflow, occupancy[$clog2(MAX_OUT):0]}. Narrower values are zero-extended.

## Timing
- Reset values: rd_data 0, rd_valid 0, all counters 0, min_lat all-ones (TS_W), flags 0, FIFOs empty, ts 0, last_start_valid 0.
- A statistic updates on the clock edge that samples the event. A read in the following cycle returns the new value.
- Read latency 1: rd_en in cycle N → rd_data/rd_valid in cycle N+1. rd_valid is high for exactly one cycle per rd_en. rd_data holds its last value otherwise.
- Latency is measured from the start-accept edge to the done-accept edge. A done event one cycle after its start gives lat = 1.
- Reset mid-transaction discards all outstanding timestamps.

## Configuration
- PERF_MON_STALL_EN defined: done_stall and start_stall counters are built and count while enable is high.
- Not defined: no stall logic is generated; rd_sel 5 and 6 read 0.

## Structure
- Package ap_perf_pkg holds the rd_sel encoding localparams (SEL_TXN … SEL_STATUS), a ts_t typedef, and the per-channel stats struct.
- Sub-module ap_ctrl_chan_monitor, one instance per channel via generate. It contains the timestamp FIFO, event decode and statistics. The top level holds ts, the read mux and the output register.

## Test plan
- Single transaction: ch0 start at ts=10, done at ts=17 → txn_count=1, last_lat=min_lat=max_lat=7, occupancy=0.
- Overlap: ch2 starts at ts=0, 3, 6; dones at ts=20, 21, 22 → lats 20, 18, 16; min=16, max=20; last_ii=3.
- Overflow, MAX_OUT=4: 5 starts with no done → occupancy=4, overflow=1. Then a same-cycle start+done while full → occupancy stays 4, lat recorded.
- Underflow: done on an idle channel → txn_count=1, underflow=1, min_lat still all-ones.
- Stall (with PERF_MON_STALL_EN): ap_done high for 5 cycles with ap_continue low, then both high → done_stall=5, txn_count=1. Without the macro, rd_sel=5 reads 0.
- Clear and enable: clear asserted together with a done event → all statistics 0. With enable=0, 3 transactions → txn_count stays 0. Reset mid-busy → status reads 0.
